touch_avalon_bridge: RTL and testbench
======================================

TOUCH_AVALON_BRIDGE -- requirements
Module: touch_avalon_bridge

Interface
REQ-001 SHALL have parameter N_POINTS, default 5, number of touch points (1..10).
REQ-002 SHALL have parameter X_W, default 10, X coordinate width; Y_W, default 9, Y coordinate width; X_W+Y_W <= 31.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, gesture FIFO depth (power of 2, 2..64).
REQ-004 SHALL have parameter ADDR_W, default 4, word address width; 4+N_POINTS <= 2^ADDR_W.
REQ-005 Ports: one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 address  in  ADDR_W  Avalon-MM word address.
REQ-009 read  in  1  read strobe; write  in  1  write strobe.
REQ-010 writedata  in  32  write data.
REQ-011 readdata  out  32  registered read data; readdatavalid  out  1  read data qualifier.
REQ-012 irq  out  1  level interrupt, registered.
REQ-013 sample_valid  in  1  one-cycle strobe: new controller sample.
REQ-014 sample_xy  in  N_POINTS*(X_W+Y_W)  point i at slice i: {y_i, x_i}, x in LSBs.
REQ-015 sample_count  in  4  touch count; sample_gest  in  8  gesture code, 0 = none.

Function
REQ-016 Register map: 0 CTRL (RW), 1 STATUS (RW1C), 2 COUNT (RO), 3 GEST (RO, pop on read), 4..4+N_POINTS-1 POINT[i] (RO); other addresses read 0, writes ignored.
REQ-017 CTRL: bit0 touch_ie, bit1 gest_ie, bit2 freeze; other bits read 0.
REQ-018 STATUS: bit0 new_touch, bit1 new_gest, bit2 gest_ovf, bits[15:8] seq; writing 1 to bits 0..2 clears them; seq read-only.
REQ-019 Snapshot: sample_valid with freeze=0 latches all points, count into shadow registers in one cycle, sets new_touch, seq += 1 (wraps 255->0).
REQ-020 sample_valid with freeze=1: snapshot, new_touch, seq unchanged; gesture path still active.
REQ-021 POINT[i] reads {zeros, y_i, x_i} zero-extended to 32 bits; COUNT reads {28'h0, count}.
REQ-022 Gesture push: sample_valid and sample_gest != 0; sets new_gest.
REQ-023 GEST read: FIFO non-empty -> {1'b1, 23'h0, code}, entry popped; empty -> 0, no pop.
REQ-024 Push when full and no pop same cycle: new code dropped, gest_ovf set, contents unchanged.
REQ-025 Push and pop same cycle when full: both succeed, no overflow, level unchanged.
REQ-026 Push and pop same cycle when empty: read returns 0, pushed entry stored.
REQ-027 Read latency exactly 1: readdata and readdatavalid registered, readdatavalid = read delayed one cycle; readdata holds otherwise.
REQ-028 STATUS bit set and W1C of same bit in same cycle: set wins.
REQ-029 irq = (new_touch & touch_ie) | ((new_gest | gest_ovf) & gest_ie), registered, 1-cycle lag.
REQ-030 read and write asserted together: both executed; readdata shows pre-write value.

Reset
REQ-031 reset SHALL clear CTRL, STATUS, seq, all snapshot registers, FIFO pointers/level, readdata, readdatavalid, irq to 0.
REQ-032 reset mid-operation SHALL take precedence over any same-cycle read, write or sample_valid; FIFO contents discarded.

Configuration
REQ-033 Macro TOUCH_GEST_FIFO_EN defined: gesture FIFO of FIFO_DEPTH entries per REQ-022..026.
REQ-034 TOUCH_GEST_FIFO_EN undefined: single gesture register, last nonzero code overwrites, GEST read returns {1, code} once then 0 until next push; gest_ovf set when an unread code is overwritten.

Verification
REQ-035 Reset, then sample_valid with count=3, point0 x=0x155 y=0x0AA -> COUNT reads 3, POINT[0] reads 0x00015555, seq=1, readdatavalid one cycle after read.
REQ-036 CTRL=0x1, sample_valid -> irq=1 two cycles after strobe; write STATUS=0x1 -> irq=0 after 1 cycle.
REQ-037 Push 9 gestures 1..9, FIFO_DEPTH=8, no reads -> gest_ovf=1, GEST reads 0x80000001..0x80000008, ninth read 0.
REQ-038 FIFO full, GEST read same cycle as push code 0x42 -> no overflow, 0x42 last of 8 popped.
REQ-039 CTRL=0x4, sample_valid with new coords -> POINT/COUNT/seq unchanged, gesture still queued.
REQ-040 W1C of new_gest in same cycle as gesture push -> new_gest remains 1.

Source files
------------

// File: rtl/touch_avalon_bridge.sv
// Avalon-MM slave that exposes touch-controller snapshots, STATUS/IRQ and a gesture queue.
// Define TOUCH_GEST_FIFO_EN for a FIFO_DEPTH-entry gesture FIFO; otherwise a single overwrite register is used.
module touch_avalon_bridge #(
    parameter int N_POINTS   = 5,
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             address,
    input  logic                          read,
    input  logic                          write,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic                          readdatavalid,
    output logic                          irq,
    input  logic                          sample_valid,
    input  logic [N_POINTS*(X_W+Y_W)-1:0] sample_xy,
    input  logic [3:0]                    sample_count,
    input  logic [7:0]                    sample_gest
);
    localparam int PW = X_W + Y_W;
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_GEST   = ADDR_W'(3);

    logic [2:0]             ctrl_q, ctrl_d;
    logic                   touch_q, touch_d, ngest_q, ngest_d, ovf_q, ovf_d;
    logic [7:0]             seq_q, seq_d;
    logic [N_POINTS*PW-1:0] pts_q, pts_d;
    logic [3:0]             count_q, count_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   rdv_q, irq_q, irq_d;
    logic [2:0]             clr;
    logic                   snap;

    logic       gest_push, gest_pop, gest_avail, gest_ovf_set;
    logic [7:0] gest_head;

    assign gest_push = sample_valid && (sample_gest != 8'h00);
    assign gest_pop  = read && (address == A_GEST) && gest_avail;

`ifdef TOUCH_GEST_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = FIFO_DEPTH[PTR_W:0];

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             full, push_ok;

    assign full         = (level_q == FULL_LVL);
    assign gest_avail   = (level_q != '0);
    assign gest_head    = mem_q[rd_ptr_q];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok      = gest_push && (!full || gest_pop);
    assign gest_ovf_set = gest_push && full && !gest_pop;

    always_comb begin
        wr_ptr_d = push_ok  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = gest_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, gest_pop};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage array is not reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= sample_gest;
    end
`else
    logic [7:0] code_q, code_d;
    logic       valid_q, valid_d;

    assign gest_avail   = valid_q;
    assign gest_head    = code_q;
    assign gest_ovf_set = gest_push && valid_q && !gest_pop;

    always_comb begin
        code_d  = gest_push ? sample_gest : code_q;
        valid_d = gest_push || (valid_q && !gest_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end
`endif

    assign snap = sample_valid && !ctrl_q[2];
    assign clr  = (write && (address == A_STATUS)) ? writedata[2:0] : 3'b000;

    // NOTE: every next-state value gets a default first so no latch is inferred.
    always_comb begin
        ctrl_d  = ctrl_q;
        pts_d   = pts_q;
        count_d = count_q;
        seq_d   = seq_q;
        rdata_d = rdata_q;

        if (write && (address == A_CTRL)) ctrl_d = writedata[2:0];

        if (snap) begin
            pts_d   = sample_xy;
            count_d = sample_count;
            seq_d   = seq_q + 8'd1;
        end

        // Set beats a same-cycle write-1-to-clear.
        touch_d = (touch_q & ~clr[0]) | snap;
        ngest_d = (ngest_q & ~clr[1]) | gest_push;
        ovf_d   = (ovf_q   & ~clr[2]) | gest_ovf_set;

        if (read) begin
            rdata_d = '0;
            case (address)
                A_CTRL:   rdata_d = {29'h0, ctrl_q};
                A_STATUS: rdata_d = {16'h0, seq_q, 5'h0, ovf_q, ngest_q, touch_q};
                A_COUNT:  rdata_d = {28'h0, count_q};
                A_GEST:   rdata_d = gest_avail ? {1'b1, 23'h0, gest_head} : 32'h0;
                default: begin
                    for (int i = 0; i < N_POINTS; i++) begin
                        if (address == ADDR_W'(4 + i)) rdata_d = {{(32-PW){1'b0}}, pts_q[i*PW +: PW]};
                    end
                end
            endcase
        end

        irq_d = (touch_q & ctrl_q[0]) | ((ngest_q | ovf_q) & ctrl_q[1]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q  <= '0;
            touch_q <= 1'b0;
            ngest_q <= 1'b0;
            ovf_q   <= 1'b0;
            seq_q   <= '0;
            pts_q   <= '0;
            count_q <= '0;
            rdata_q <= '0;
            rdv_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            touch_q <= touch_d;
            ngest_q <= ngest_d;
            ovf_q   <= ovf_d;
            seq_q   <= seq_d;
            pts_q   <= pts_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            rdv_q   <= read;
            irq_q   <= irq_d;
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rdv_q;
    assign irq           = irq_q;
endmodule

// File: tb/tb_touch_avalon_bridge.sv
// Randomized bench for touch_avalon_bridge against a queue-based register-map model.
// X_W=9 / Y_W=10 so that point (x=0x155, y=0x0AA) packs to 0x15555.
module tb_touch_avalon_bridge;
    localparam int N_POINTS   = 5;
    localparam int X_W        = 9;
    localparam int Y_W        = 10;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = 4;
    localparam int PW         = X_W + Y_W;
`ifdef TOUCH_GEST_FIFO_EN
    localparam int CAP       = FIFO_DEPTH;
    localparam bit OVERWRITE = 1'b0;
`else
    localparam int CAP       = 1;
    localparam bit OVERWRITE = 1'b1;
`endif

    logic                   clock = 1'b0;
    logic                   reset, read, write, sample_valid;
    logic [ADDR_W-1:0]      address;
    logic [31:0]            writedata, readdata;
    logic                   readdatavalid, irq;
    logic [N_POINTS*PW-1:0] sample_xy;
    logic [3:0]             sample_count;
    logic [7:0]             sample_gest;

    touch_avalon_bridge #(
        .N_POINTS(N_POINTS), .X_W(X_W), .Y_W(Y_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid), .irq(irq),
        .sample_valid(sample_valid), .sample_xy(sample_xy), .sample_count(sample_count),
        .sample_gest(sample_gest)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: register-map state plus a gesture queue bounded by CAP.
    logic [2:0]    m_ctrl;
    logic          m_nt, m_ng, m_ovf;
    logic [7:0]    m_seq;
    logic [PW-1:0] m_pt [N_POINTS];
    logic [3:0]    m_cnt;
    logic [7:0]    m_q [$];
    logic [31:0]   m_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_nt = 1'b0; m_ng = 1'b0; m_ovf = 1'b0; m_seq = '0; m_cnt = '0;
        m_rdata = '0;
        for (int i = 0; i < N_POINTS; i++) m_pt[i] = '0;
        m_q.delete();
    endtask

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return {29'h0, m_ctrl};
        if (a == 1) return {16'h0, m_seq, 5'h0, m_ovf, m_ng, m_nt};
        if (a == 2) return {28'h0, m_cnt};
        if (a == 3) return (m_q.size() > 0) ? (32'h8000_0000 | {24'h0, m_q[0]}) : 32'h0;
        if (a >= 4 && a < 4 + N_POINTS) return 32'(m_pt[a-4]);
        return 32'h0;
    endfunction

    // One clock: drive inputs, advance the model, then check all outputs #1 after the edge.
    task automatic cycle(input bit rst, input bit rd, input bit wr, input int a, input logic [31:0] wd,
                         input bit sv, input logic [3:0] cnt, input logic [7:0] g,
                         input logic [N_POINTS*PW-1:0] xy);
        logic       exp_irq;
        logic [2:0] clr, set;
        reset = rst; read = rd; write = wr; address = ADDR_W'(a); writedata = wd;
        sample_valid = sv; sample_count = cnt; sample_gest = g; sample_xy = xy;
        if (rst) begin
            model_reset();
            exp_irq = 1'b0;
        end else begin
            exp_irq = (m_nt & m_ctrl[0]) | ((m_ng | m_ovf) & m_ctrl[1]);
            if (rd) m_rdata = m_read(a);
            clr = (wr && a == 1) ? wd[2:0] : 3'b000;
            set = 3'b000;
            if (sv && !m_ctrl[2]) begin
                for (int i = 0; i < N_POINTS; i++) m_pt[i] = xy[i*PW +: PW];
                m_cnt = cnt;
                m_seq = m_seq + 8'd1;
                set[0] = 1'b1;
            end
            if (rd && a == 3 && m_q.size() > 0) void'(m_q.pop_front());
            if (sv && g != 8'h00) begin
                set[1] = 1'b1;
                if (m_q.size() < CAP) m_q.push_back(g);
                else begin
                    set[2] = 1'b1;
                    if (OVERWRITE) m_q[0] = g;
                end
            end
            m_nt  = (m_nt  & ~clr[0]) | set[0];
            m_ng  = (m_ng  & ~clr[1]) | set[1];
            m_ovf = (m_ovf & ~clr[2]) | set[2];
            if (wr && a == 0) m_ctrl = wd[2:0];
        end
        @(posedge clock);
        #1;
        check("readdata", readdata, m_rdata);
        check("readdatavalid", {31'h0, readdatavalid}, {31'h0, rd & ~rst});
        check("irq", {31'h0, irq}, {31'h0, exp_irq});
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 32'h0, 0, 4'h0, 8'h00, '0);
    endtask
    task automatic rd_reg(input int a);
        cycle(0, 1, 0, a, 32'h0, 0, 4'h0, 8'h00, '0);
    endtask
    task automatic wr_reg(input int a, input logic [31:0] d);
        cycle(0, 0, 1, a, d, 0, 4'h0, 8'h00, '0);
    endtask
    task automatic sample(input logic [3:0] cnt, input logic [7:0] g, input logic [N_POINTS*PW-1:0] xy);
        cycle(0, 0, 0, 0, 32'h0, 1, cnt, g, xy);
    endtask
    task automatic drain();
        for (int k = 0; k < CAP + 2 && m_q.size() > 0; k++) rd_reg(3);
    endtask

    function automatic logic [N_POINTS*PW-1:0] rand_xy();
        logic [N_POINTS*PW-1:0] xy;
        for (int i = 0; i < N_POINTS; i++) xy[i*PW +: PW] = PW'($urandom);
        return xy;
    endfunction

    initial begin
        logic [N_POINTS*PW-1:0] xy;
        logic [3:0]             save_cnt;
        logic [PW-1:0]          save_pt0;
        logic [7:0]             save_seq;
        model_reset();
        cycle(1, 0, 0, 0, 32'h0, 0, 4'h0, 8'h00, '0);
        cycle(1, 0, 0, 0, 32'h0, 0, 4'h0, 8'h00, '0);
        rd_reg(0);
        check("reset_ctrl", readdata, 32'h0);
        rd_reg(1);
        check("reset_status", readdata, 32'h0);

        // Snapshot of count 3 with point 0 = (x 0x155, y 0x0AA).
        xy = '0;
        xy[PW-1:0] = {10'h0AA, 9'h155};
        sample(4'd3, 8'h00, xy);
        rd_reg(2);
        check("count", readdata, 32'h3);
        check("rdv_after_read", {31'h0, readdatavalid}, 32'h1);
        idle();
        check("rdv_drop", {31'h0, readdatavalid}, 32'h0);
        rd_reg(4);
        check("point0", readdata, 32'h0001_5555);
        rd_reg(1);
        check("seq_first", {24'h0, readdata[15:8]}, 32'h1);

        // Touch interrupt: raised two edges after the strobe, drops one edge after W1C.
        wr_reg(1, 32'h7);
        wr_reg(0, 32'h1);
        sample(4'd1, 8'h00, rand_xy());
        check("irq_lag", {31'h0, irq}, 32'h0);
        idle();
        check("irq_on", {31'h0, irq}, 32'h1);
        wr_reg(1, 32'h1);
        check("irq_hold", {31'h0, irq}, 32'h1);
        idle();
        check("irq_off", {31'h0, irq}, 32'h0);

        // Nine pushes with no reads.
        wr_reg(0, 32'h0);
        wr_reg(1, 32'h7);
        for (int k = 1; k <= 9; k++) sample(4'd2, 8'(k), rand_xy());
        rd_reg(1);
        check("gest_ovf", {31'h0, readdata[2]}, 32'h1);
`ifdef TOUCH_GEST_FIFO_EN
        for (int k = 1; k <= 8; k++) begin
            rd_reg(3);
            check("gest_order", readdata, 32'h8000_0000 | 32'(k));
        end
`else
        rd_reg(3);
        check("gest_last", readdata, 32'h8000_0009);
`endif
        rd_reg(3);
        check("gest_empty", readdata, 32'h0);

        // Full queue, pop and push 0x42 together.
        wr_reg(1, 32'h7);
        for (int k = 0; k < CAP; k++) sample(4'd1, 8'(8'h11 + k), rand_xy());
        cycle(0, 1, 0, 3, 32'h0, 1, 4'd1, 8'h42, rand_xy());
        check("full_pop", readdata, 32'h8000_0011);
        rd_reg(1);
        check("full_pop_no_ovf", {31'h0, readdata[2]}, 32'h0);
        for (int k = 1; k < CAP; k++) begin
            rd_reg(3);
            check("full_drain", readdata, 32'h8000_0011 + 32'(k));
        end
        rd_reg(3);
        check("last_42", readdata, 32'h8000_0042);
        rd_reg(3);
        check("after_42", readdata, 32'h0);

        // Empty queue, pop and push together.
        cycle(0, 1, 0, 3, 32'h0, 1, 4'd1, 8'h5C, rand_xy());
        check("empty_pop", readdata, 32'h0);
        rd_reg(3);
        check("empty_push_kept", readdata, 32'h8000_005C);

        // Freeze holds the snapshot but still queues gestures.
        wr_reg(0, 32'h4);
        wr_reg(1, 32'h7);
        save_cnt = m_cnt; save_pt0 = m_pt[0]; save_seq = m_seq;
        sample(~save_cnt, 8'h33, ~{N_POINTS{save_pt0}});
        rd_reg(2);
        check("freeze_count", readdata, {28'h0, save_cnt});
        rd_reg(4);
        check("freeze_point0", readdata, 32'(save_pt0));
        rd_reg(1);
        check("freeze_seq", {24'h0, readdata[15:8]}, {24'h0, save_seq});
        check("freeze_no_touch", {31'h0, readdata[0]}, 32'h0);
        rd_reg(3);
        check("freeze_gest", readdata, 32'h8000_0033);

        // W1C of new_gest loses to a same-cycle push.
        wr_reg(0, 32'h0);
        wr_reg(1, 32'h7);
        cycle(0, 0, 1, 1, 32'h2, 1, 4'd1, 8'h5A, rand_xy());
        rd_reg(1);
        check("set_wins", {31'h0, readdata[1]}, 32'h1);

        // Read and write STATUS together: old value returned, then cleared.
        cycle(0, 1, 1, 1, 32'h7, 0, 4'h0, 8'h00, '0);
        check("rw_pre_value", {31'h0, readdata[1]}, 32'h1);
        rd_reg(1);
        check("rw_cleared", {29'h0, readdata[2:0]}, 32'h0);

        // Reset beats same-cycle read, write and sample.
        cycle(1, 1, 1, 0, 32'h7, 1, 4'd5, 8'h77, rand_xy());
        check("rst_rdv", {31'h0, readdatavalid}, 32'h0);
        rd_reg(3);
        check("rst_gest", readdata, 32'h0);
        rd_reg(0);
        check("rst_ctrl", readdata, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit             rst, rd, wr, sv;
            int             a;
            logic [31:0]    wd;
            logic [7:0]     g;
            rst = ($urandom_range(0, 399) == 0);
            rd  = ($urandom_range(0, 1) == 1);
            wr  = ($urandom_range(0, 3) == 0);
            a   = $urandom_range(0, 15);
            wd  = $urandom;
            sv  = ($urandom_range(0, 2) == 0);
            g   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            cycle(rst, rd, wr, a, wd, sv, 4'($urandom), g, rand_xy());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
